regfile_access_controller: RTL

REGFILE_ACCESS_CONTROLLER -- requirements
Module: regfile_access_controller

---
 rtl/regfile_access_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/regfile_access_controller.sv
// rtl/regfile_access_controller.sv - queued single-outstanding register file access controller
// Requests are buffered in a small FIFO and executed one at a time against a 1-cycle-latency register file.
module regfile_access_controller #(
    parameter int P_RegCount  = 3,
    parameter int P_BitWidth  = 32,
    parameter int P_FifoDepth = 4,
    localparam int AW = (P_RegCount > 1) ? $clog2(P_RegCount) : 1
) (
    input  logic                  In_Clock_50MHz,
    input  logic                  In_Reset_n,
    input  logic                  In_ReqValid,
    output logic                  Out_ReqReady,
    input  logic                  In_ReqWrite,
    input  logic [AW-1:0]         In_ReqAddress,
    input  logic [P_BitWidth-1:0] In_ReqData,
    output logic [AW-1:0]         Out_RF_Address,
    output logic [P_BitWidth-1:0] Out_RF_WriteData,
    output logic                  Out_RF_Write,
    output logic                  Out_RF_Read,
    input  logic [P_BitWidth-1:0] In_RF_ReadData,
    output logic                  Out_RspValid,
    input  logic                  In_RspReady,
    output logic [P_BitWidth-1:0] Out_RspData,
    output logic                  Out_RspError
);

    localparam int PW = (P_FifoDepth > 1) ? $clog2(P_FifoDepth) : 1;
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(P_FifoDepth);
    localparam logic [AW:0] REG_LIMIT  = (AW + 1)'(P_RegCount);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t state, state_next;

    logic                  fifo_write [P_FifoDepth];
    logic [AW-1:0]         fifo_addr  [P_FifoDepth];
    logic [P_BitWidth-1:0] fifo_data  [P_FifoDepth];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           fifo_count, count_next;
    logic                  req_ready;
    logic                  push, pop;

    logic                  cmd_write;
    logic [AW-1:0]         cmd_addr;
    logic [P_BitWidth-1:0] cmd_data;
    logic                  cmd_error;
    logic [P_BitWidth-1:0] rsp_data;
    logic                  rsp_error;

    assign push      = In_ReqValid && req_ready;
    assign pop       = (state == IDLE) && (fifo_count != '0);
    assign cmd_error = ({1'b0, cmd_addr} >= REG_LIMIT);

    always_comb begin
        count_next = fifo_count;
        case ({push, pop})
            2'b10:   count_next = fifo_count + 1'b1;
            2'b01:   count_next = fifo_count - 1'b1;
            default: count_next = fifo_count;
        endcase
    end

    // Ready is registered so it is low throughout reset and only depends on the committed count.
    always_ff @(posedge In_Clock_50MHz or negedge In_Reset_n) begin
        if (!In_Reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            req_ready  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= count_next;
            req_ready  <= (count_next != FULL_COUNT);
        end
    end

    always_ff @(posedge In_Clock_50MHz) begin
        if (push) begin
            fifo_write[wr_ptr] <= In_ReqWrite;
            fifo_addr[wr_ptr]  <= In_ReqAddress;
            fifo_data[wr_ptr]  <= In_ReqData;
        end
    end

    always_ff @(posedge In_Clock_50MHz or negedge In_Reset_n) begin
        if (!In_Reset_n) begin
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
        end else begin
            if (pop) begin
                cmd_write <= fifo_write[rd_ptr];
                cmd_addr  <= fifo_addr[rd_ptr];
                cmd_data  <= fifo_data[rd_ptr];
            end
            if (state == ISSUE) begin
                rsp_data  <= '0;
                rsp_error <= cmd_error;
            end
            if (state == CAPTURE) begin
                rsp_data  <= In_RF_ReadData;
                rsp_error <= 1'b0;
            end
        end
    end

    always_ff @(posedge In_Clock_50MHz or negedge In_Reset_n) begin
        if (!In_Reset_n) state <= IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next   = state;
        Out_RF_Write = 1'b0;
        Out_RF_Read  = 1'b0;
        Out_RspValid = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) state_next = ISSUE;
            end
            ISSUE: begin
                if (cmd_error) begin
                    state_next = RESP;
                end else if (cmd_write) begin
                    Out_RF_Write = 1'b1;
                    state_next   = RESP;
                end else begin
                    Out_RF_Read = 1'b1;
                    state_next  = CAPTURE;
                end
            end
            CAPTURE: state_next = RESP;
            RESP: begin
                Out_RspValid = 1'b1;
                if (In_RspReady) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign Out_ReqReady     = req_ready;
    assign Out_RF_Address   = cmd_addr;
    assign Out_RF_WriteData = cmd_data;
    assign Out_RspData      = rsp_data;
    assign Out_RspError     = rsp_error;

endmodule
